// File: rtl/ring_buffer_pkg.sv
// Shared helpers for the ring buffer family: counter/pointer widths and wrap-around increment.
//  cnt_width(length) : bits needed to hold 0..length
//  ptr_width(length) : bits needed to index 0..length-1
//  ptr_next(p, len)  : p+1 with explicit wrap len-1 -> 0 (any depth, not only powers of two)
package ring_buffer_pkg;

  function automatic int unsigned cnt_width(input int unsigned length);
    return $clog2(length + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned length);
    return (length > 1) ? $clog2(length) : 1;
  endfunction

  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned length);
    return (ptr == length - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/ring_buffer_ex_if.sv
// Producer/consumer bus of ring_buffer_ex.
//  master : drives flush_i, enqueue_i, dequeue_i, data_i; observes data/status outputs
//  slave  : the buffer itself (inverse directions)
interface ring_buffer_ex_if
  import ring_buffer_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LENGTH = 5
);
  localparam int unsigned CW = cnt_width(LENGTH);

  logic             flush_i;
  logic             enqueue_i;
  logic             dequeue_i;
  logic [WIDTH-1:0] data_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    level_o;
  logic             overflow_o;
  logic             underflow_o;

  modport master (
    output flush_i, enqueue_i, dequeue_i, data_i,
    input  data_o, valid_o, full, empty, almost_full, almost_empty,
           level_o, overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, enqueue_i, dequeue_i, data_i,
    output data_o, valid_o, full, empty, almost_full, almost_empty,
           level_o, overflow_o, underflow_o
  );

endinterface

// File: rtl/ring_ptr.sv
// Wrapping pointer 0..LENGTH-1 for one side of the ring buffer.
//  clk, rst : clock, synchronous active-high reset
//  inc_i    : advance by one (wraps LENGTH-1 -> 0)
//  clr_i    : synchronous clear to 0, overrides inc_i
//  ptr_o    : current pointer
module ring_ptr
  import ring_buffer_pkg::*;
#(
  parameter  int unsigned LENGTH = 5,
  localparam int unsigned PW     = ptr_width(LENGTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [PW-1:0] ptr_o
);

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      ptr_o <= '0;
    end else if (inc_i) begin
      ptr_o <= PW'(ptr_next(32'(ptr_o), LENGTH));
    end
  end

endmodule

// File: rtl/ring_buffer_ex.sv
// Single-clock circular FIFO of arbitrary depth with overwrite mode, fill level,
// almost-full/almost-empty thresholds, flush and sticky overflow/underflow flags.
//  clk, rst : clock, synchronous active-high reset
//  bus      : ring_buffer_ex_if.slave (requests, write data, read data, status)
// All outputs are registered; status flags are decoded from the next level value.
module ring_buffer_ex
  import ring_buffer_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned LENGTH       = 5,
  parameter int unsigned OVERWRITABLE = 0,
  parameter int unsigned AF_LEVEL     = 4,
  parameter int unsigned AE_LEVEL     = 1
) (
  input logic             clk,
  input logic             rst,
  ring_buffer_ex_if.slave bus
);

  localparam int unsigned CW  = cnt_width(LENGTH);
  localparam int unsigned PW  = ptr_width(LENGTH);
  localparam bit          OVW = (OVERWRITABLE != 0);

  logic [WIDTH-1:0] mem [LENGTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  logic [CW-1:0]    level_q;
  logic [CW-1:0]    level_nxt;
  logic             full_q;
  logic             empty_q;
  logic             af_q;
  logic             ae_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             ovf_q;
  logic             udf_q;

  logic             do_enq_c;
  logic             do_deq_c;
  logic             loss_c;
  logic             overwrite_c;
  logic             wr_inc_c;
  logic             rd_inc_c;

  // Request resolution against registered full/empty; flush cancels everything.
  always_comb begin
    do_deq_c    = bus.dequeue_i && !empty_q;
    loss_c      = bus.enqueue_i && full_q && !bus.dequeue_i;
    overwrite_c = loss_c && OVW;
    do_enq_c    = bus.enqueue_i && (!full_q || do_deq_c || OVW);
    wr_inc_c    = do_enq_c && !bus.flush_i;
    rd_inc_c    = (do_deq_c || overwrite_c) && !bus.flush_i;
    level_nxt   = level_q;
    if (bus.flush_i) begin
      level_nxt = '0;
    end else if (do_enq_c && !do_deq_c && !overwrite_c) begin
      level_nxt = level_q + CW'(1);
    end else if (do_deq_c && !do_enq_c) begin
      level_nxt = level_q - CW'(1);
    end
  end

  ring_ptr #(.LENGTH(LENGTH)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (wr_inc_c),
    .clr_i (bus.flush_i),
    .ptr_o (wr_ptr)
  );

  ring_ptr #(.LENGTH(LENGTH)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (rd_inc_c),
    .clr_i (bus.flush_i),
    .ptr_o (rd_ptr)
  );

  // Storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_inc_c) begin
      mem[wr_ptr] <= bus.data_i;
    end
  end

  // Level, status flags, read data and sticky loss flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      level_q <= level_nxt;
      full_q  <= (level_nxt == CW'(LENGTH));
      empty_q <= (level_nxt == '0);
      af_q    <= (level_nxt >= CW'(AF_LEVEL));
      ae_q    <= (level_nxt <= CW'(AE_LEVEL));
      if (bus.flush_i) begin
        valid_q <= 1'b0;
        ovf_q   <= 1'b0;
        udf_q   <= 1'b0;
      end else begin
        valid_q <= do_deq_c;
        if (do_deq_c) begin
          data_q <= mem[rd_ptr];
        end
        if (loss_c) begin
          ovf_q <= 1'b1;
        end
        if (bus.dequeue_i && empty_q) begin
          udf_q <= 1'b1;
        end
      end
    end
  end

  assign bus.data_o       = data_q;
  assign bus.valid_o      = valid_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.level_o      = level_q;
  assign bus.overflow_o   = ovf_q;
  assign bus.underflow_o  = udf_q;

endmodule

// File: tb/tb_ring_buffer_ex.sv
// Directed bench for ring_buffer_ex: dut0 drop mode, dut1 overwrite mode (WIDTH=8, LENGTH=5,
// AF_LEVEL=4, AE_LEVEL=1).
module tb_ring_buffer_ex;

  logic clk = 1'b0;
  logic rst;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ring_buffer_ex_if #(.WIDTH(8), .LENGTH(5)) b0 ();
  ring_buffer_ex_if #(.WIDTH(8), .LENGTH(5)) b1 ();

  ring_buffer_ex #(
    .WIDTH(8), .LENGTH(5), .OVERWRITABLE(0), .AF_LEVEL(4), .AE_LEVEL(1)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  ring_buffer_ex #(
    .WIDTH(8), .LENGTH(5), .OVERWRITABLE(1), .AF_LEVEL(4), .AE_LEVEL(1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b0.flush_i = 1'b0; b0.enqueue_i = 1'b0; b0.dequeue_i = 1'b0; b0.data_i = 8'h00;
    b1.flush_i = 1'b0; b1.enqueue_i = 1'b0; b1.dequeue_i = 1'b0; b1.data_i = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  q[$];
    logic [7:0]  v;
    logic [7:0]  exp_d;
    int unsigned lvl;

    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // 1 reset state
    check("rst_empty",  32'(b0.empty), 32'd1);
    check("rst_full",   32'(b0.full), 32'd0);
    check("rst_level",  32'(b0.level_o), 32'd0);
    check("rst_ae",     32'(b0.almost_empty), 32'd1);
    check("rst_af",     32'(b0.almost_full), 32'd0);
    check("rst_data",   32'(b0.data_o), 32'd0);
    check("rst_valid",  32'(b0.valid_o), 32'd0);
    check("rst_ovf",    32'(b0.overflow_o), 32'd0);
    check("rst_udf",    32'(b0.underflow_o), 32'd0);
    check("rst_empty1", 32'(b1.empty), 32'd1);

    // 2/3/5 fill 'a'..'g' on both buffers, thresholds on the way
    for (int i = 0; i < 7; i++) begin
      b0.enqueue_i = 1'b1; b0.data_i = 8'h61 + 8'(i);
      b1.enqueue_i = 1'b1; b1.data_i = 8'h61 + 8'(i);
      tick();
      lvl = (i + 1 > 5) ? 5 : i + 1;
      check($sformatf("fill_level0_%0d", i), 32'(b0.level_o), lvl);
      check($sformatf("fill_level1_%0d", i), 32'(b1.level_o), lvl);
      check($sformatf("fill_full_%0d", i),   32'(b0.full), 32'(lvl == 5));
      check($sformatf("fill_ovf0_%0d", i),   32'(b0.overflow_o), 32'(i >= 5));
      check($sformatf("fill_ovf1_%0d", i),   32'(b1.overflow_o), 32'(i >= 5));
      check($sformatf("fill_af_%0d", i),     32'(b0.almost_full), 32'(lvl >= 4));
      check($sformatf("fill_ae_%0d", i),     32'(b0.almost_empty), 32'(lvl <= 1));
    end
    idle();

    // drain 6: drop mode returns a..e, overwrite mode c..g; 6th underflows
    for (int i = 0; i < 6; i++) begin
      b0.dequeue_i = 1'b1;
      b1.dequeue_i = 1'b1;
      tick();
      if (i < 5) begin
        check($sformatf("drain_valid0_%0d", i), 32'(b0.valid_o), 32'd1);
        check($sformatf("drain_data0_%0d", i),  32'(b0.data_o), 32'h61 + 32'(i));
        check($sformatf("drain_data1_%0d", i),  32'(b1.data_o), 32'h63 + 32'(i));
        check($sformatf("drain_udf0_%0d", i),   32'(b0.underflow_o), 32'd0);
        check($sformatf("drain_level_%0d", i),  32'(b0.level_o), 32'(4 - i));
        check($sformatf("drain_ae_%0d", i),     32'(b0.almost_empty), 32'((4 - i) <= 1));
        check($sformatf("drain_af_%0d", i),     32'(b0.almost_full), 32'((4 - i) >= 4));
      end else begin
        check("drain_valid0_last", 32'(b0.valid_o), 32'd0);
        check("drain_hold0_last",  32'(b0.data_o), 32'h65);
        check("drain_hold1_last",  32'(b1.data_o), 32'h67);
        check("drain_udf0_last",   32'(b0.underflow_o), 32'd1);
        check("drain_udf1_last",   32'(b1.underflow_o), 32'd1);
        check("drain_empty_last",  32'(b0.empty), 32'd1);
      end
    end
    idle();

    // 4 flush to clear flags, preload 3, then 12 simultaneous cycles across the wrap
    b0.flush_i = 1'b1;
    tick();
    idle();
    check("flush_ovf", 32'(b0.overflow_o), 32'd0);
    check("flush_udf", 32'(b0.underflow_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      v = 8'h10 + 8'(k);
      b0.enqueue_i = 1'b1; b0.data_i = v;
      q.push_back(v);
      tick();
    end
    check("preload_level", 32'(b0.level_o), 32'd3);
    for (int i = 0; i < 12; i++) begin
      v = 8'h20 + 8'(i);
      b0.enqueue_i = 1'b1; b0.dequeue_i = 1'b1; b0.data_i = v;
      exp_d = q.pop_front();
      q.push_back(v);
      tick();
      check($sformatf("wrap_data_%0d", i),  32'(b0.data_o), 32'(exp_d));
      check($sformatf("wrap_valid_%0d", i), 32'(b0.valid_o), 32'd1);
      check($sformatf("wrap_level_%0d", i), 32'(b0.level_o), 32'd3);
    end
    idle();
    check("wrap_ovf", 32'(b0.overflow_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      b0.dequeue_i = 1'b1;
      exp_d = q.pop_front();
      tick();
      check($sformatf("wdrain_data_%0d", i), 32'(b0.data_o), 32'(exp_d));
    end
    idle();
    check("wdrain_empty", 32'(b0.empty), 32'd1);

    // simultaneous enqueue+dequeue while empty
    b0.enqueue_i = 1'b1; b0.dequeue_i = 1'b1; b0.data_i = 8'h77;
    tick();
    idle();
    check("simempty_level", 32'(b0.level_o), 32'd1);
    check("simempty_udf",   32'(b0.underflow_o), 32'd1);
    check("simempty_valid", 32'(b0.valid_o), 32'd0);
    b0.dequeue_i = 1'b1;
    tick();
    idle();
    check("simempty_read",  32'(b0.data_o), 32'h77);
    check("simempty_rv",    32'(b0.valid_o), 32'd1);
    check("simempty_lvl0",  32'(b0.level_o), 32'd0);

    // 6 overflow, drain to level 3, then flush with enqueue on the same edge
    for (int k = 0; k < 6; k++) begin
      b0.enqueue_i = 1'b1; b0.data_i = 8'h31 + 8'(k);
      tick();
    end
    idle();
    check("pre_flush_ovf", 32'(b0.overflow_o), 32'd1);
    for (int k = 0; k < 2; k++) begin
      b0.dequeue_i = 1'b1;
      tick();
    end
    idle();
    check("pre_flush_level", 32'(b0.level_o), 32'd3);
    check("pre_flush_data",  32'(b0.data_o), 32'h32);
    b0.flush_i = 1'b1; b0.enqueue_i = 1'b1; b0.data_i = 8'hEE;
    tick();
    idle();
    check("fl_level", 32'(b0.level_o), 32'd0);
    check("fl_empty", 32'(b0.empty), 32'd1);
    check("fl_ovf",   32'(b0.overflow_o), 32'd0);
    check("fl_udf",   32'(b0.underflow_o), 32'd0);
    check("fl_valid", 32'(b0.valid_o), 32'd0);
    check("fl_hold",  32'(b0.data_o), 32'h32);
    check("fl_ae",    32'(b0.almost_empty), 32'd1);
    b0.dequeue_i = 1'b1;
    tick();
    idle();
    check("postfl_valid", 32'(b0.valid_o), 32'd0);
    check("postfl_udf",   32'(b0.underflow_o), 32'd1);
    b0.enqueue_i = 1'b1; b0.data_i = 8'h55;
    tick();
    idle();
    b0.dequeue_i = 1'b1;
    tick();
    idle();
    check("postfl_data", 32'(b0.data_o), 32'h55);
    check("postfl_rv",   32'(b0.valid_o), 32'd1);
    tick();
    check("valid_pulse", 32'(b0.valid_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
